// File: rtl/vram_arbiter.sv
// Two-port VRAM arbiter: VGA scan-out has priority, the sand engine gets a
// forced grant after waiting STARVE_LIMIT cycles. Read data returns 2 cycles after grant.
module vram_arbiter #(
    parameter int VRAM_ADDR_WIDTH = 19,
    parameter int VRAM_DATA_WIDTH = 1,
    parameter int STARVE_LIMIT    = 15
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       disp_req_i,
    input  logic [VRAM_ADDR_WIDTH-1:0] disp_addr_i,
    output logic [VRAM_DATA_WIDTH-1:0] disp_rdata_o,
    output logic                       disp_rvalid_o,
    output logic                       disp_miss_o,
    input  logic                       eng_req_i,
    input  logic                       eng_we_i,
    input  logic [VRAM_ADDR_WIDTH-1:0] eng_addr_i,
    input  logic [VRAM_DATA_WIDTH-1:0] eng_wdata_i,
    output logic                       eng_gnt_o,
    output logic [VRAM_DATA_WIDTH-1:0] eng_rdata_o,
    output logic                       eng_rvalid_o,
    output logic [VRAM_ADDR_WIDTH-1:0] vram_addr_o,
    output logic                       vram_we_o,
    output logic [VRAM_DATA_WIDTH-1:0] vram_wdata_o,
    input  logic [VRAM_DATA_WIDTH-1:0] vram_rdata_i
);

    localparam int WAIT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

    localparam logic [1:0] TAG_NONE = 2'd0;
    localparam logic [1:0] TAG_DISP = 2'd1;
    localparam logic [1:0] TAG_ENG  = 2'd2;

    logic [WAIT_W-1:0]          wait_cnt_reg;
    logic [WAIT_W-1:0]          wait_cnt_next;
    logic [1:0]                 tag1_reg;
    logic [1:0]                 tag1_next;
    logic [1:0]                 tag2_reg;
    logic [VRAM_ADDR_WIDTH-1:0] vram_addr_reg;
    logic                       vram_we_reg;
    logic [VRAM_DATA_WIDTH-1:0] vram_wdata_reg;

    logic starve;
    logic disp_sel;
    logic disp_win;
    logic eng_win;

    always_comb begin
        starve        = (STARVE_LIMIT > 0) && (wait_cnt_reg == WAIT_MAX) && eng_req_i;
        // disp_sel is the pre-reset priority decision; reset only masks the grants
        disp_sel      = disp_req_i && !starve;
        disp_win      = disp_sel && !reset_i;
        eng_win       = eng_req_i && !disp_sel && !reset_i;
        wait_cnt_next = wait_cnt_reg;
        if (eng_win || !eng_req_i) begin
            wait_cnt_next = '0;
        end else if (wait_cnt_reg != WAIT_MAX) begin
            wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
        end
        tag1_next = TAG_NONE;
        if (disp_win) begin
            tag1_next = TAG_DISP;
        end else if (eng_win && !eng_we_i) begin
            tag1_next = TAG_ENG;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            vram_addr_reg  <= '0;
            vram_we_reg    <= 1'b0;
            vram_wdata_reg <= '0;
            tag1_reg       <= TAG_NONE;
            tag2_reg       <= TAG_NONE;
            wait_cnt_reg   <= '0;
        end else begin
            if (disp_win) begin
                vram_addr_reg <= disp_addr_i;
                vram_we_reg   <= 1'b0;
            end else if (eng_win) begin
                vram_addr_reg  <= eng_addr_i;
                vram_we_reg    <= eng_we_i;
                vram_wdata_reg <= eng_wdata_i;
            end else begin
                vram_we_reg <= 1'b0;
            end
            tag1_reg     <= tag1_next;
            tag2_reg     <= tag1_reg;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    assign vram_addr_o   = vram_addr_reg;
    assign vram_we_o     = vram_we_reg;
    assign vram_wdata_o  = vram_wdata_reg;
    assign eng_gnt_o     = eng_win;
    assign disp_miss_o   = starve && disp_req_i && !reset_i;

    // Returning read data is steered straight from the VRAM bus to its owner
    assign disp_rvalid_o = (tag2_reg == TAG_DISP);
    assign eng_rvalid_o  = (tag2_reg == TAG_ENG);
    assign disp_rdata_o  = disp_rvalid_o ? vram_rdata_i : '0;
    assign eng_rdata_o   = eng_rvalid_o ? vram_rdata_i : '0;

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomized and directed checks of vram_arbiter against a cycle-level
// behavioural model of the arbitration, starvation and read-return rules.
module tb_vram_arbiter;

    localparam int AW    = 19;
    localparam int DW    = 1;
    localparam int LIMIT = 15;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          disp_req_i;
    logic [AW-1:0] disp_addr_i;
    logic          eng_req_i;
    logic          eng_we_i;
    logic [AW-1:0] eng_addr_i;
    logic [DW-1:0] eng_wdata_i;
    logic [DW-1:0] vram_rdata_i;

    logic [DW-1:0] disp_rdata_o;
    logic          disp_rvalid_o;
    logic          disp_miss_o;
    logic          eng_gnt_o;
    logic [DW-1:0] eng_rdata_o;
    logic          eng_rvalid_o;
    logic [AW-1:0] vram_addr_o;
    logic          vram_we_o;
    logic [DW-1:0] vram_wdata_o;

    logic [DW-1:0] z_disp_rdata;
    logic          z_disp_rvalid;
    logic          z_disp_miss;
    logic          z_eng_gnt;
    logic [DW-1:0] z_eng_rdata;
    logic          z_eng_rvalid;
    logic [AW-1:0] z_vram_addr;
    logic          z_vram_we;
    logic [DW-1:0] z_vram_wdata;

    int n_checks = 0;
    int n_errors = 0;

    // behavioural model state
    logic [AW-1:0] m_addr  = '0;
    logic          m_we    = 1'b0;
    logic [DW-1:0] m_wdata = '0;
    int            m_own1  = 0;   // 0 none, 1 display, 2 engine read
    int            m_own2  = 0;
    int            m_waited = 0;
    logic          m_gnt   = 1'b0;

    always #5 clk_i = ~clk_i;

    vram_arbiter #(.VRAM_ADDR_WIDTH(AW), .VRAM_DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .disp_req_i(disp_req_i), .disp_addr_i(disp_addr_i),
        .disp_rdata_o(disp_rdata_o), .disp_rvalid_o(disp_rvalid_o), .disp_miss_o(disp_miss_o),
        .eng_req_i(eng_req_i), .eng_we_i(eng_we_i), .eng_addr_i(eng_addr_i),
        .eng_wdata_i(eng_wdata_i), .eng_gnt_o(eng_gnt_o), .eng_rdata_o(eng_rdata_o),
        .eng_rvalid_o(eng_rvalid_o), .vram_addr_o(vram_addr_o), .vram_we_o(vram_we_o),
        .vram_wdata_o(vram_wdata_o), .vram_rdata_i(vram_rdata_i)
    );

    vram_arbiter #(.VRAM_ADDR_WIDTH(AW), .VRAM_DATA_WIDTH(DW), .STARVE_LIMIT(0)) dut_nostarve (
        .clk_i(clk_i), .reset_i(reset_i),
        .disp_req_i(disp_req_i), .disp_addr_i(disp_addr_i),
        .disp_rdata_o(z_disp_rdata), .disp_rvalid_o(z_disp_rvalid), .disp_miss_o(z_disp_miss),
        .eng_req_i(eng_req_i), .eng_we_i(eng_we_i), .eng_addr_i(eng_addr_i),
        .eng_wdata_i(eng_wdata_i), .eng_gnt_o(z_eng_gnt), .eng_rdata_o(z_eng_rdata),
        .eng_rvalid_o(z_eng_rvalid), .vram_addr_o(z_vram_addr), .vram_we_o(z_vram_we),
        .vram_wdata_o(z_vram_wdata), .vram_rdata_i(vram_rdata_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string ctx);
        check({ctx, "_vram_addr"}, 32'(vram_addr_o), 0);
        check({ctx, "_vram_we"}, 32'(vram_we_o), 0);
        check({ctx, "_vram_wdata"}, 32'(vram_wdata_o), 0);
        check({ctx, "_disp_rdata"}, 32'(disp_rdata_o), 0);
        check({ctx, "_disp_rvalid"}, 32'(disp_rvalid_o), 0);
        check({ctx, "_disp_miss"}, 32'(disp_miss_o), 0);
        check({ctx, "_eng_rdata"}, 32'(eng_rdata_o), 0);
        check({ctx, "_eng_rvalid"}, 32'(eng_rvalid_o), 0);
        check({ctx, "_eng_gnt"}, 32'(eng_gnt_o), 0);
    endtask

    task automatic model_reset();
        m_addr = '0; m_we = 1'b0; m_wdata = '0;
        m_own1 = 0; m_own2 = 0; m_waited = 0; m_gnt = 1'b0;
    endtask

    // One clock cycle: drive inputs, compare every output with the model, advance the model.
    task automatic step(input logic dr, input logic [AW-1:0] da, input logic er, input logic ew,
                        input logic [AW-1:0] ea, input logic [DW-1:0] ewd);
        logic forced, dwin, miss;
        @(negedge clk_i);
        disp_req_i = dr; disp_addr_i = da;
        eng_req_i = er; eng_we_i = ew; eng_addr_i = ea; eng_wdata_i = ewd;
        vram_rdata_i = DW'($urandom_range(0, 1));
        #1;
        forced = (LIMIT > 0) && er && (m_waited >= LIMIT);
        dwin   = dr && !forced;
        m_gnt  = er && !dwin;
        miss   = dr && forced;

        check("vram_we", 32'(vram_we_o), 32'(m_we));
        check("vram_addr", 32'(vram_addr_o), 32'(m_addr));
        if (m_we) check("vram_wdata", 32'(vram_wdata_o), 32'(m_wdata));
        check("disp_rvalid", 32'(disp_rvalid_o), 32'(m_own2 == 1));
        check("eng_rvalid", 32'(eng_rvalid_o), 32'(m_own2 == 2));
        if (m_own2 == 1) check("disp_rdata", 32'(disp_rdata_o), 32'(vram_rdata_i));
        if (m_own2 == 2) check("eng_rdata", 32'(eng_rdata_o), 32'(vram_rdata_i));
        check("eng_gnt", 32'(eng_gnt_o), 32'(m_gnt));
        check("disp_miss", 32'(disp_miss_o), 32'(miss));

        m_own2 = m_own1;
        if (dwin) begin
            m_own1 = 1; m_addr = da; m_we = 1'b0;
        end else if (m_gnt) begin
            m_own1 = ew ? 0 : 2; m_addr = ea; m_we = ew; m_wdata = ewd;
        end else begin
            m_own1 = 0; m_we = 1'b0;
        end
        if (m_gnt || !er) m_waited = 0;
        else if (m_waited < LIMIT) m_waited++;
    endtask

    initial begin
        int first_gnt;
        logic miss_at;
        logic e_pend;
        logic e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;

        reset_i = 1'b1;
        disp_req_i = 0; disp_addr_i = '0; eng_req_i = 0; eng_we_i = 0;
        eng_addr_i = '0; eng_wdata_i = '0; vram_rdata_i = '0;
        #2;
        check_all_zero("por");
        @(posedge clk_i); #2;
        reset_i = 1'b0;

        // display-only read of 0x00005
        step(1, 19'h00005, 0, 0, '0, '0);
        step(0, '0, 0, 0, '0, '0);
        check("disp_addr5", 32'(vram_addr_o), 32'h5);
        step(0, '0, 0, 0, '0, '0);
        step(0, '0, 0, 0, '0, '0);

        // engine write then read of 0x12C00
        step(0, '0, 1, 1, 19'h12C00, 1'b1);
        check("eng_wr_gnt", 32'(eng_gnt_o), 1);
        step(0, '0, 1, 0, 19'h12C00, 1'b0);
        check("eng_rd_gnt", 32'(eng_gnt_o), 1);
        check("eng_wr_we", 32'(vram_we_o), 1);
        step(0, '0, 0, 0, '0, '0);
        check("eng_rd_we", 32'(vram_we_o), 0);
        step(0, '0, 0, 0, '0, '0);
        check("eng_rd_rvalid", 32'(eng_rvalid_o), 1);
        step(0, '0, 0, 0, '0, '0);
        check("eng_rd_single", 32'(eng_rvalid_o), 0);

        // contention: forced grant on the 16th cycle
        first_gnt = 0; miss_at = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step(1, 19'(i), 1, 0, 19'h00ABC, '0);
            if (eng_gnt_o && first_gnt == 0) begin
                first_gnt = i;
                miss_at = disp_miss_o;
            end
        end
        check("starve_cycle", 32'(first_gnt), 16);
        check("starve_miss", 32'(miss_at), 1);

        // STARVE_LIMIT=0 instance never yields to the engine
        for (int i = 0; i < 100; i++) begin
            step(1, 19'(i), 1, 0, 19'h00123, '0);
            check("nostarve_gnt", 32'(z_eng_gnt), 0);
            check("nostarve_miss", 32'(z_disp_miss), 0);
        end

        // idle: address holds, no write, no returns
        for (int i = 0; i < 4; i++) step(0, 19'h7FFFF, 0, 0, 19'h7FFFF, '0);

        // reset in the cycle after a display grant
        step(1, 19'h00042, 0, 0, '0, '0);
        @(posedge clk_i); #2;
        disp_req_i = 1; eng_req_i = 1;
        reset_i = 1'b1;
        #1;
        check_all_zero("midrst");
        @(posedge clk_i); #2;
        reset_i = 1'b0;
        disp_req_i = 0; eng_req_i = 0;
        model_reset();
        for (int i = 0; i < 4; i++) step(0, '0, 0, 0, '0, '0);

        // randomized traffic; engine holds its request until granted
        e_pend = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0;
        for (int i = 0; i < 400; i++) begin
            if (!e_pend && $urandom_range(0, 2) != 0) begin
                e_pend = 1'b1;
                e_we   = 1'($urandom_range(0, 1));
                e_addr = AW'($urandom);
                e_wd   = DW'($urandom_range(0, 1));
            end
            step(($urandom_range(0, 9) < 8), AW'($urandom), e_pend, e_we, e_addr, e_wd);
            if (m_gnt) e_pend = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
